// File: rtl/kernel_wb_pkg.sv
// Shared types and constants for the kernel result write-back controller:
// FSM states, status-line field layout and line geometry helper.
package kernel_wb_pkg;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    HOLDOFF   = 3'd1,
    WAIT_DONE = 3'd2,
    FETCH     = 3'd3,
    EMIT      = 3'd4,
    STATUS    = 3'd5
  } wb_state_e;

  localparam int ADDR_W        = 42;
  localparam int STAT_FLAG_LSB = 0;
  localparam int STAT_FLAG_W   = 64;
  localparam int STAT_LEN_LSB  = 64;
  localparam int STAT_CYC_LSB  = 96;
  localparam int STAT_FIELD_W  = 32;

  function automatic int words_per_line(input int line_w, input int slot_w);
    return line_w / slot_w;
  endfunction

endpackage

// File: rtl/kernel_wb_if.sv
// Host-memory line write channel between the write-back controller and the
// CCI-MPF side.
interface kernel_wb_if #(
  parameter int LINE_W = 512
) ();
  import kernel_wb_pkg::*;

  logic              wr_valid;
  logic [ADDR_W-1:0] wr_addr;
  logic [LINE_W-1:0] wr_data;
  logic              wr_almfull;

  modport master (output wr_valid, output wr_addr, output wr_data, input wr_almfull);
  modport slave  (input wr_valid, input wr_addr, input wr_data, output wr_almfull);

endinterface

// File: rtl/kernel_wb_line_packer.sv
// Slot-indexed line buffer: tracks outstanding exit-memory reads through an
// RD_LAT-deep tag pipeline and drops each returned word into its slot.
module kernel_wb_line_packer
  import kernel_wb_pkg::*;
#(
  parameter int  DATA_W     = 24,
  parameter int  SLOT_W     = 32,
  parameter int  LINE_W     = 512,
  parameter int  RD_LAT     = 1,
  localparam int SLOT_IDX_W = $clog2(words_per_line(LINE_W, SLOT_W))
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  clear,
  input  logic                  issue,
  input  logic [SLOT_IDX_W-1:0] issue_slot,
  input  logic [DATA_W-1:0]     rd_data,
  output logic                  ret_vld,
  output logic [LINE_W-1:0]     line
);

  logic [RD_LAT-1:0]     vld_pipe_r;
  logic [SLOT_IDX_W-1:0] slot_pipe_r [RD_LAT];
  logic [LINE_W-1:0]     line_r;

  // Carry each read's slot tag alongside its valid bit until the data returns.
  always_ff @(posedge clk) begin
    if (reset) begin
      vld_pipe_r <= '0;
      for (int i = 0; i < RD_LAT; i++) slot_pipe_r[i] <= '0;
    end else begin
      vld_pipe_r[0]  <= issue;
      slot_pipe_r[0] <= issue_slot;
      for (int i = 1; i < RD_LAT; i++) begin
        vld_pipe_r[i]  <= vld_pipe_r[i-1];
        slot_pipe_r[i] <= slot_pipe_r[i-1];
      end
    end
  end

  assign ret_vld = vld_pipe_r[RD_LAT-1];

  // Line storage; each word is zero-extended so unused slot bits stay 0.
  always_ff @(posedge clk) begin
    if (reset) begin
      line_r <= '0;
    end else if (clear) begin
      line_r <= '0;
    end else if (ret_vld) begin
      line_r[slot_pipe_r[RD_LAT-1]*SLOT_W +: SLOT_W] <= SLOT_W'(rd_data);
    end
  end

  assign line = line_r;

endmodule

// File: rtl/kernel_result_writeback.sv
// Starts a fixed-function kernel, times it, then streams its exit memory to
// host memory as packed lines followed by a completion status line.
module kernel_result_writeback
  import kernel_wb_pkg::*;
#(
  parameter int  DATA_W        = 24,
  parameter int  SLOT_W        = 32,
  parameter int  LINE_W        = 512,
  parameter int  DEPTH         = 4096,
  parameter int  RD_LAT        = 1,
  parameter int  START_HOLDOFF = 10,
  localparam int RD_ADDR_W     = $clog2(DEPTH)
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 cfg_wr_en,
  input  logic [ADDR_W-1:0]    cfg_base_addr,
  input  logic [RD_ADDR_W:0]   cfg_len,
  output logic                 k_start,
  input  logic                 k_done,
  output logic [RD_ADDR_W-1:0] k_rd_addr,
  input  logic [DATA_W-1:0]    k_rd_data,
  kernel_wb_if.master          wr,
  output logic                 busy
);

  localparam int LEN_W      = RD_ADDR_W + 1;
  localparam int WPL        = words_per_line(LINE_W, SLOT_W);
  localparam int SLOT_IDX_W = $clog2(WPL);
  localparam int CNT_W      = SLOT_IDX_W + 1;
  localparam int HO_W       = $clog2(START_HOLDOFF + 1);

  wb_state_e             state_r, state_nxt_s;
  logic [ADDR_W-1:0]     base_r;
  logic [LEN_W-1:0]      len_r, word_idx_r, line_idx_r;
  logic [CNT_W-1:0]      issue_cnt_r, ret_cnt_r;
  logic [HO_W-1:0]       holdoff_cnt_r;
  logic [31:0]           cycle_cnt_r;
  logic                  k_start_r, wr_valid_r, busy_r;
  logic [RD_ADDR_W-1:0]  k_rd_addr_r;
  logic [ADDR_W-1:0]     wr_addr_r;
  logic [LINE_W-1:0]     wr_data_r;

  logic                  issue_room_s, rd_fire_s, fetch_done_s, more_s, wr_go_s;
  logic                  clear_s, ret_vld_s;
  logic [LEN_W-1:0]      len_clamp_s, nlines_s;
  logic [LINE_W-1:0]     line_s, status_line_s;

  assign wr_go_s      = !wr.wr_almfull;
  assign more_s       = (word_idx_r < len_r);
  assign issue_room_s = (issue_cnt_r < CNT_W'(WPL)) && more_s;
  assign rd_fire_s    = (state_r == FETCH) && issue_room_s;
  assign fetch_done_s = !issue_room_s && (ret_cnt_r == issue_cnt_r);
  assign nlines_s     = (len_r + LEN_W'(WPL - 1)) >> SLOT_IDX_W;
  assign len_clamp_s  = (cfg_len > LEN_W'(DEPTH)) ? LEN_W'(DEPTH) : cfg_len;
  assign clear_s      = ((state_r == IDLE) && cfg_wr_en) ||
                        ((state_r == EMIT) && wr_go_s && more_s);

  // Status line layout: completion flag, word count, kernel cycle count.
  always_comb begin
    status_line_s = '0;
    status_line_s[STAT_FLAG_LSB +: STAT_FLAG_W] = 64'd1;
    status_line_s[STAT_LEN_LSB  +: STAT_FIELD_W] = STAT_FIELD_W'(len_r);
    status_line_s[STAT_CYC_LSB  +: STAT_FIELD_W] = cycle_cnt_r;
  end

  kernel_wb_line_packer #(
    .DATA_W (DATA_W),
    .SLOT_W (SLOT_W),
    .LINE_W (LINE_W),
    .RD_LAT (RD_LAT)
  ) u_packer (
    .clk        (clk),
    .reset      (reset),
    .clear      (clear_s),
    .issue      (rd_fire_s),
    .issue_slot (issue_cnt_r[SLOT_IDX_W-1:0]),
    .rd_data    (k_rd_data),
    .ret_vld    (ret_vld_s),
    .line       (line_s)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (reset) state_r <= IDLE;
    else       state_r <= state_nxt_s;
  end

  // Next-state decode.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      IDLE:      if (cfg_wr_en) state_nxt_s = HOLDOFF; else state_nxt_s = IDLE;
      HOLDOFF:   if (holdoff_cnt_r == HO_W'(START_HOLDOFF - 1)) state_nxt_s = WAIT_DONE;
                 else state_nxt_s = HOLDOFF;
      WAIT_DONE: if (k_done) state_nxt_s = (len_r != LEN_W'(0)) ? FETCH : STATUS;
                 else state_nxt_s = WAIT_DONE;
      FETCH:     if (fetch_done_s) state_nxt_s = EMIT; else state_nxt_s = FETCH;
      EMIT:      if (wr_go_s) state_nxt_s = more_s ? FETCH : STATUS; else state_nxt_s = EMIT;
      STATUS:    if (wr_go_s) state_nxt_s = IDLE; else state_nxt_s = STATUS;
      default:   state_nxt_s = IDLE;
    endcase
  end

  // Counters, read addressing and registered write-channel outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      base_r <= '0; len_r <= '0; word_idx_r <= '0; line_idx_r <= '0;
      issue_cnt_r <= '0; ret_cnt_r <= '0; holdoff_cnt_r <= '0; cycle_cnt_r <= '0;
      k_start_r <= 1'b0; k_rd_addr_r <= '0; wr_valid_r <= 1'b0;
      wr_addr_r <= '0; wr_data_r <= '0; busy_r <= 1'b0;
    end else begin
      k_start_r  <= 1'b0;
      wr_valid_r <= 1'b0;
      case (state_r)
        IDLE: if (cfg_wr_en) begin
          base_r        <= cfg_base_addr;
          len_r         <= len_clamp_s;
          cycle_cnt_r   <= '0;
          holdoff_cnt_r <= '0;
          word_idx_r    <= '0;
          line_idx_r    <= '0;
          issue_cnt_r   <= '0;
          ret_cnt_r     <= '0;
          k_start_r     <= 1'b1;
          busy_r        <= 1'b1;
        end
        HOLDOFF: begin
          holdoff_cnt_r <= holdoff_cnt_r + HO_W'(1);
          if (cycle_cnt_r != 32'hFFFF_FFFF) cycle_cnt_r <= cycle_cnt_r + 32'd1;
        end
        WAIT_DONE: begin
          if (k_done) begin
            if (len_r != LEN_W'(0)) k_rd_addr_r <= '0;
          end else if (cycle_cnt_r != 32'hFFFF_FFFF) begin
            cycle_cnt_r <= cycle_cnt_r + 32'd1;
          end
        end
        FETCH: begin
          if (rd_fire_s) begin
            word_idx_r  <= word_idx_r + LEN_W'(1);
            issue_cnt_r <= issue_cnt_r + CNT_W'(1);
            // Hold at len-1 so the address never wraps past the last word.
            if ((word_idx_r + LEN_W'(1)) < len_r) k_rd_addr_r <= k_rd_addr_r + RD_ADDR_W'(1);
          end
          if (ret_vld_s) ret_cnt_r <= ret_cnt_r + CNT_W'(1);
        end
        EMIT: if (wr_go_s) begin
          wr_valid_r <= 1'b1;
          wr_addr_r  <= base_r + ADDR_W'(line_idx_r);
          wr_data_r  <= line_s;
          if (more_s) begin
            line_idx_r  <= line_idx_r + LEN_W'(1);
            issue_cnt_r <= '0;
            ret_cnt_r   <= '0;
          end
        end
        STATUS: if (wr_go_s) begin
          wr_valid_r <= 1'b1;
          wr_addr_r  <= base_r + ADDR_W'(nlines_s);
          wr_data_r  <= status_line_s;
          busy_r     <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  assign k_start     = k_start_r;
  assign k_rd_addr   = k_rd_addr_r;
  assign busy        = busy_r;
  assign wr.wr_valid = wr_valid_r;
  assign wr.wr_addr  = wr_addr_r;
  assign wr.wr_data  = wr_data_r;

endmodule

// File: tb/tb_kernel_result_writeback.sv
// Drives an RD_LAT=1 and an RD_LAT=3 instance in lockstep and scores every
// line write against a word-list model of the expected host buffer.
module tb_kernel_result_writeback;

  typedef struct packed {
    logic [41:0]  addr;
    logic [511:0] data;
  } wr_t;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         cfg_wr_en = 1'b0;
  logic [41:0]  cfg_base_addr = '0;
  logic [12:0]  cfg_len = '0;
  logic         k_done = 1'b0;
  logic         wr_almfull = 1'b0;
  logic         k_start1, k_start3, busy1, busy3;
  logic [11:0]  k_rd_addr1, k_rd_addr3;
  logic [23:0]  k_rd_data1, k_rd_data3;
  logic [23:0]  mem [4096];
  logic [23:0]  rd1_q;
  logic [23:0]  rd3_q [3];

  int  n_checks = 0;
  int  n_fail = 0;
  wr_t got_q [2][$];
  bit  busy_wr [2][$];
  wr_t exp_q [$];
  int  alm_viol [2] = '{0, 0};
  bit  alm_prev = 1'b0;
  int  ks_cnt [2];
  bit  addr_moved [2];
  int  viol0 [2];
  int  pre_rel [2];
  bit  timed_out;

  always #5 clk = ~clk;

  kernel_wb_if #(.LINE_W(512)) wif1 ();
  kernel_wb_if #(.LINE_W(512)) wif3 ();
  assign wif1.wr_almfull = wr_almfull;
  assign wif3.wr_almfull = wr_almfull;

  kernel_result_writeback #(.RD_LAT(1)) u_dut1 (
    .clk(clk), .reset(reset), .cfg_wr_en(cfg_wr_en), .cfg_base_addr(cfg_base_addr),
    .cfg_len(cfg_len), .k_start(k_start1), .k_done(k_done), .k_rd_addr(k_rd_addr1),
    .k_rd_data(k_rd_data1), .wr(wif1), .busy(busy1));

  kernel_result_writeback #(.RD_LAT(3)) u_dut3 (
    .clk(clk), .reset(reset), .cfg_wr_en(cfg_wr_en), .cfg_base_addr(cfg_base_addr),
    .cfg_len(cfg_len), .k_start(k_start3), .k_done(k_done), .k_rd_addr(k_rd_addr3),
    .k_rd_data(k_rd_data3), .wr(wif3), .busy(busy3));

  // Kernel exit memories with one- and three-cycle read latency.
  always @(posedge clk) begin
    rd1_q    <= mem[k_rd_addr1];
    rd3_q[0] <= mem[k_rd_addr3];
    rd3_q[1] <= rd3_q[0];
    rd3_q[2] <= rd3_q[1];
  end
  assign k_rd_data1 = rd1_q;
  assign k_rd_data3 = rd3_q[2];

  // Write-channel monitor.
  always @(negedge clk) begin
    if (!reset) begin
      if (wif1.wr_valid) begin got_q[0].push_back({wif1.wr_addr, wif1.wr_data}); busy_wr[0].push_back(busy1); end
      if (wif3.wr_valid) begin got_q[1].push_back({wif3.wr_addr, wif3.wr_data}); busy_wr[1].push_back(busy3); end
      if (wif1.wr_valid && alm_prev) alm_viol[0] <= alm_viol[0] + 1;
      if (wif3.wr_valid && alm_prev) alm_viol[1] <= alm_viol[1] + 1;
    end
    alm_prev <= wr_almfull;
  end

  // Expected host buffer: data lines of zero-extended words, then status.
  task automatic build_exp(input logic [41:0] base, input int len, input int cyc);
    int nl;
    logic [511:0] ln;
    exp_q.delete();
    nl = (len + 15) / 16;
    for (int l = 0; l < nl; l++) begin
      ln = '0;
      for (int i = 0; i < 16; i++)
        if (l * 16 + i < len) ln[i*32 +: 32] = {8'h00, mem[l*16+i]};
      exp_q.push_back({base + 42'(l), ln});
    end
    ln = '0;
    ln[63:0]   = 64'd1;
    ln[95:64]  = 32'(len);
    ln[127:96] = 32'(cyc);
    exp_q.push_back({base + 42'(nl), ln});
  endtask

  task automatic run_job(input logic [41:0] base, input logic [12:0] len_in,
                         input int done_at, input int alm_from, input int alm_len);
    logic [11:0] a1, a3;
    for (int d = 0; d < 2; d++) begin
      got_q[d].delete(); busy_wr[d].delete();
      ks_cnt[d] = 0; addr_moved[d] = 1'b0; viol0[d] = alm_viol[d]; pre_rel[d] = -1;
    end
    timed_out = 1'b1;
    a1 = k_rd_addr1; a3 = k_rd_addr3;
    @(posedge clk); #1;
    cfg_wr_en = 1'b1; cfg_base_addr = base; cfg_len = len_in;
    @(posedge clk); #1;
    cfg_wr_en = 1'b0;
    for (int c = 0; c < 20000; c++) begin
      if (c == done_at) k_done = 1'b1;
      wr_almfull = (c >= alm_from) && (c < alm_from + alm_len);
      if (alm_len > 0 && c == alm_from + alm_len) begin
        pre_rel[0] = got_q[0].size(); pre_rel[1] = got_q[1].size();
      end
      @(negedge clk);
      ks_cnt[0] += int'(k_start1); ks_cnt[1] += int'(k_start3);
      if (k_rd_addr1 != a1) addr_moved[0] = 1'b1;
      if (k_rd_addr3 != a3) addr_moved[1] = 1'b1;
      if (!busy1 && !busy3) begin timed_out = 1'b0; break; end
      @(posedge clk); #1;
    end
    repeat (2) @(negedge clk);
    k_done = 1'b0; wr_almfull = 1'b0;
  endtask

  task automatic test_reset();
    @(negedge clk);
    n_checks++;
    if ({k_start1, busy1, k_rd_addr1, wif1.wr_valid, wif1.wr_addr, wif1.wr_data} !== '0) begin
      n_fail++; $display("FAIL reset dut1: outputs not all zero (k_start %b busy %b wr_valid %b)", k_start1, busy1, wif1.wr_valid);
    end
    n_checks++;
    if ({k_start3, busy3, k_rd_addr3, wif3.wr_valid, wif3.wr_addr, wif3.wr_data} !== '0) begin
      n_fail++; $display("FAIL reset dut3: outputs not all zero (k_start %b busy %b wr_valid %b)", k_start3, busy3, wif3.wr_valid);
    end
    @(posedge clk); #1 reset = 1'b0;
  endtask

  task automatic test_len16();
    logic [41:0] base = 42'h12_3456_7800;
    run_job(base, 13'd16, 40, 0, 0);
    build_exp(base, 16, 40);
    n_checks++;
    if (timed_out !== 1'b0) begin n_fail++; $display("FAIL len16 timeout: busy still %b/%b expected 0", busy1, busy3); end
    for (int d = 0; d < 2; d++) begin
      n_checks++;
      if (ks_cnt[d] !== 1) begin n_fail++; $display("FAIL len16 k_start dut%0d: high %0d cycles expected 1", d, ks_cnt[d]); end
      n_checks++;
      if (got_q[d].size() !== exp_q.size()) begin
        n_fail++; $display("FAIL len16 writes dut%0d: got %0d expected %0d", d, got_q[d].size(), exp_q.size());
      end else begin
        for (int k = 0; k < exp_q.size(); k++) begin
          n_checks++;
          if (got_q[d][k] !== exp_q[k]) begin
            n_fail++; $display("FAIL len16 line%0d dut%0d: got %h/%h expected %h/%h", k, d, got_q[d][k].addr, got_q[d][k].data, exp_q[k].addr, exp_q[k].data);
          end
        end
        n_checks++;
        if (busy_wr[d][0] !== 1'b1) begin n_fail++; $display("FAIL len16 busy dut%0d: busy %b during data write expected 1", d, busy_wr[d][0]); end
      end
    end
    n_checks++;
    if ({busy1, busy3} !== 2'b00) begin n_fail++; $display("FAIL len16 busy_end: got %b%b expected 00", busy1, busy3); end
  endtask

  task automatic test_len20();
    logic [41:0] base = 42'h0AB_CDEF_0010;
    run_job(base, 13'd20, 25, 0, 0);
    build_exp(base, 20, 25);
    for (int d = 0; d < 2; d++) begin
      n_checks++;
      if (got_q[d].size() !== exp_q.size()) begin
        n_fail++; $display("FAIL len20 writes dut%0d: got %0d expected %0d", d, got_q[d].size(), exp_q.size());
      end else begin
        for (int k = 0; k < exp_q.size(); k++) begin
          n_checks++;
          if (got_q[d][k] !== exp_q[k]) begin
            n_fail++; $display("FAIL len20 line%0d dut%0d: got %h/%h expected %h/%h", k, d, got_q[d][k].addr, got_q[d][k].data, exp_q[k].addr, exp_q[k].data);
          end
        end
      end
    end
  endtask

  task automatic test_len0();
    logic [41:0] base = 42'h000_0000_4000;
    run_job(base, 13'd0, 15, 0, 0);
    build_exp(base, 0, 15);
    for (int d = 0; d < 2; d++) begin
      n_checks++;
      if (ks_cnt[d] !== 1) begin n_fail++; $display("FAIL len0 k_start dut%0d: high %0d cycles expected 1", d, ks_cnt[d]); end
      n_checks++;
      if (addr_moved[d] !== 1'b0) begin n_fail++; $display("FAIL len0 rd_addr dut%0d: moved %b expected 0", d, addr_moved[d]); end
      n_checks++;
      if (got_q[d].size() !== 1 || got_q[d][0] !== exp_q[0]) begin
        n_fail++; $display("FAIL len0 status dut%0d: got %0d writes expected 1 at %h data %h", d, got_q[d].size(), exp_q[0].addr, exp_q[0].data);
      end
    end
  endtask

  task automatic test_almfull();
    logic [41:0] base = 42'h3C0_0000_0100;
    run_job(base, 13'd20, 30, 31, 30);
    build_exp(base, 20, 30);
    for (int d = 0; d < 2; d++) begin
      n_checks++;
      if (alm_viol[d] - viol0[d] !== 0) begin n_fail++; $display("FAIL almfull valid dut%0d: %0d writes under almfull expected 0", d, alm_viol[d] - viol0[d]); end
      n_checks++;
      if (pre_rel[d] !== 0) begin n_fail++; $display("FAIL almfull hold dut%0d: %0d writes before release expected 0", d, pre_rel[d]); end
      n_checks++;
      if (got_q[d].size() !== exp_q.size()) begin
        n_fail++; $display("FAIL almfull writes dut%0d: got %0d expected %0d", d, got_q[d].size(), exp_q.size());
      end else begin
        for (int k = 0; k < exp_q.size(); k++) begin
          n_checks++;
          if (got_q[d][k] !== exp_q[k]) begin
            n_fail++; $display("FAIL almfull line%0d dut%0d: got %h/%h expected %h/%h", k, d, got_q[d][k].addr, got_q[d][k].data, exp_q[k].addr, exp_q[k].data);
          end
        end
      end
    end
  endtask

  task automatic test_holdoff_done();
    logic [41:0] base = 42'h001_1111_2220;
    run_job(base, 13'd37, 3, 0, 0);
    build_exp(base, 37, 10);
    for (int d = 0; d < 2; d++) begin
      n_checks++;
      if (got_q[d].size() !== exp_q.size()) begin
        n_fail++; $display("FAIL holdoff writes dut%0d: got %0d expected %0d", d, got_q[d].size(), exp_q.size());
      end else begin
        for (int k = 0; k < exp_q.size(); k++) begin
          n_checks++;
          if (got_q[d][k] !== exp_q[k]) begin
            n_fail++; $display("FAIL holdoff line%0d dut%0d: got %h/%h expected %h/%h", k, d, got_q[d][k].addr, got_q[d][k].data, exp_q[k].addr, exp_q[k].data);
          end
        end
      end
    end
  endtask

  task automatic test_random();
    logic [63:0] r;
    logic [12:0] len_in;
    int len_eff, done_at;
    for (int j = 0; j < 4; j++) begin
      r = {$urandom(), $urandom()};
      len_in  = (j == 3) ? 13'h1FFF : 13'($urandom_range(70, 1));
      len_eff = (int'(len_in) > 4096) ? 4096 : int'(len_in);
      done_at = $urandom_range(50, 0);
      run_job(r[41:0], len_in, done_at, 0, 0);
      build_exp(r[41:0], len_eff, (done_at > 10) ? done_at : 10);
      n_checks++;
      if (timed_out !== 1'b0) begin n_fail++; $display("FAIL random%0d timeout: busy %b/%b expected 0", j, busy1, busy3); end
      for (int d = 0; d < 2; d++) begin
        n_checks++;
        if (got_q[d].size() !== exp_q.size()) begin
          n_fail++; $display("FAIL random%0d writes dut%0d: got %0d expected %0d", j, d, got_q[d].size(), exp_q.size());
        end else begin
          for (int k = 0; k < exp_q.size(); k++) begin
            n_checks++;
            if (got_q[d][k] !== exp_q[k]) begin
              n_fail++; $display("FAIL random%0d line%0d dut%0d: got %h/%h expected %h/%h", j, k, d, got_q[d][k].addr, got_q[d][k].data, exp_q[k].addr, exp_q[k].data);
            end
          end
        end
      end
    end
  endtask

  task automatic test_reset_midfetch();
    logic [41:0] base = 42'h000_0000_0800;
    got_q[0].delete(); got_q[1].delete();
    @(posedge clk); #1;
    cfg_wr_en = 1'b1; cfg_base_addr = 42'h100; cfg_len = 13'd40;
    @(posedge clk); #1;
    cfg_wr_en = 1'b0;
    for (int c = 0; c < 19; c++) begin
      if (c == 12) k_done = 1'b1;
      if (c == 5) begin cfg_wr_en = 1'b1; cfg_base_addr = 42'h2AA; cfg_len = 13'd3; end
      else cfg_wr_en = 1'b0;
      if (c == 6) begin
        n_checks++;
        if ({k_start1, k_start3, busy1, busy3} !== 4'b0011) begin
          n_fail++; $display("FAIL busy_trigger: k_start %b%b busy %b%b expected 00 11", k_start1, k_start3, busy1, busy3);
        end
      end
      if (c == 18) reset = 1'b1;
      @(posedge clk); #1;
    end
    @(negedge clk);
    n_checks++;
    if ({k_start1, busy1, k_rd_addr1, wif1.wr_valid, wif1.wr_addr, wif1.wr_data,
         k_start3, busy3, k_rd_addr3, wif3.wr_valid, wif3.wr_addr, wif3.wr_data} !== '0) begin
      n_fail++; $display("FAIL midfetch_reset: outputs not zero (busy %b%b rd_addr %h %h)", busy1, busy3, k_rd_addr1, k_rd_addr3);
    end
    @(posedge clk); #1;
    reset = 1'b0; k_done = 1'b0;
    repeat (40) @(posedge clk);
    #1;
    n_checks++;
    if (got_q[0].size() + got_q[1].size() !== 0) begin
      n_fail++; $display("FAIL post_reset_writes: got %0d expected 0", got_q[0].size() + got_q[1].size());
    end
    run_job(base, 13'd5, 20, 0, 0);
    build_exp(base, 5, 20);
    for (int d = 0; d < 2; d++) begin
      n_checks++;
      if (got_q[d].size() !== exp_q.size()) begin
        n_fail++; $display("FAIL rerun writes dut%0d: got %0d expected %0d", d, got_q[d].size(), exp_q.size());
      end else begin
        for (int k = 0; k < exp_q.size(); k++) begin
          n_checks++;
          if (got_q[d][k] !== exp_q[k]) begin
            n_fail++; $display("FAIL rerun line%0d dut%0d: got %h/%h expected %h/%h", k, d, got_q[d][k].addr, got_q[d][k].data, exp_q[k].addr, exp_q[k].data);
          end
        end
      end
    end
  endtask

  initial begin
    for (int i = 0; i < 4096; i++) mem[i] = 24'($urandom());
    repeat (3) @(posedge clk);
    #1;
    test_reset();
    test_len16();
    test_len20();
    test_len0();
    test_almfull();
    test_holdoff_done();
    test_random();
    test_reset_midfetch();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
